// File: rtl/io_input_debounce_ctrl_pkg.sv
// Shared constants for the input-port path: read-decode codes on addr[7:2] and data width.
package io_input_pkg;
  localparam int unsigned IO_W = 32;

  localparam logic [5:0] IO_IN0_SEL  = 6'b110000;
  localparam logic [5:0] IO_IN1_SEL  = 6'b110001;
  localparam logic [5:0] IO_STAT_SEL = 6'b110010;
endpackage

// File: rtl/io_input_debounce_ctrl_if.sv
// CPU read port plus the raw board inputs feeding the debounce controller.
interface io_input_debounce_ctrl_if;
  import io_input_pkg::*;

  logic [IO_W-1:0] in_port0;
  logic [IO_W-1:0] in_port1;
  logic [31:0]     addr;
  logic            rd_en;
  logic [IO_W-1:0] io_read_data;
  logic [1:0]      change;
  logic            irq;

  modport master (
    output in_port0, in_port1, addr, rd_en,
    input  io_read_data, change, irq
  );

  modport slave (
    input  in_port0, in_port1, addr, rd_en,
    output io_read_data, change, irq
  );
endinterface

// File: rtl/io_input_debounce.sv
// One input port: 2-flop synchroniser, candidate/counter qualifier and stable register.
module io_input_debounce
  import io_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic            io_clk,
  input  logic            reset,
  input  logic [IO_W-1:0] raw_i,
  output logic [IO_W-1:0] stable_o,
  output logic            accept_o
);
  localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [IO_W-1:0] sync1_q, sync1_d;
  logic [IO_W-1:0] sync2_q, sync2_d;
  logic [IO_W-1:0] cand_q,  cand_d;
  logic [IO_W-1:0] stable_q, stable_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

  always_comb begin
    sync1_d  = raw_i;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    accept_o = 1'b0;
    // Counter saturates at CNT_MAX; acceptance only once the candidate has held that long.
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else if (cand_q != stable_q) begin
      stable_d = cand_q;
      accept_o = 1'b1;
    end
  end

  always_ff @(posedge io_clk) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
endmodule

// File: rtl/io_input_debounce_ctrl.sv
// Input-port controller: two debounced ports, read-to-clear change status, irq and read decode.
module io_input_debounce_ctrl
  import io_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                     io_clk,
  input  logic                     reset,
  io_input_debounce_ctrl_if.slave  bus
);
  logic [IO_W-1:0] stable0, stable1;
  logic [1:0]      accept;
  logic [1:0]      change_q, change_d;
  logic [5:0]      sel;
  logic            stat_clr;
  logic            addr_unused;

  io_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_port0 (
    .io_clk   (io_clk),
    .reset    (reset),
    .raw_i    (bus.in_port0),
    .stable_o (stable0),
    .accept_o (accept[0])
  );

  io_input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_port1 (
    .io_clk   (io_clk),
    .reset    (reset),
    .raw_i    (bus.in_port1),
    .stable_o (stable1),
    .accept_o (accept[1])
  );

  assign sel         = bus.addr[7:2];
  assign addr_unused = ^{bus.addr[31:8], bus.addr[1:0]};
  assign stat_clr    = bus.rd_en && (sel == IO_STAT_SEL);

  // Clear first, then OR in new acceptances so a same-edge set survives the clear.
  always_comb begin
    change_d = stat_clr ? 2'b00 : change_q;
    change_d = change_d | accept;
  end

  always_ff @(posedge io_clk) begin
    if (reset) change_q <= '0;
    else       change_q <= change_d;
  end

  always_comb begin
    bus.io_read_data = '0;
    case (sel)
      IO_IN0_SEL:  bus.io_read_data = stable0;
      IO_IN1_SEL:  bus.io_read_data = stable1;
      IO_STAT_SEL: bus.io_read_data = {{(IO_W-2){1'b0}}, change_q};
      default:     bus.io_read_data = '0;
    endcase
  end

  assign bus.change = change_q;
  assign bus.irq    = change_q[0] | change_q[1];
endmodule

// File: doc/io_input_debounce_ctrl.md
# io_input_debounce_ctrl

Controller for the memory-mapped input-port path. It synchronises and debounces the two raw input ports (switch/key banks) and latches only stable values into the port registers the CPU reads. It also tracks per-port change events in a read-to-clear status register and raises an interrupt request. It sits between the board input pins and the CPU's IO read data mux, in the io_clk domain.

## Interface
- DEBOUNCE_CYCLES, 16, cycles a synchronised value must hold unchanged before it is accepted; legal range 2..1024
- io_clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_port0  in  32  raw input port 0, asynchronous to io_clk
- in_port1  in  32  raw input port 1, asynchronous to io_clk
- addr  in  32  CPU byte address; only addr[7:2] decoded
- rd_en  in  1  CPU read strobe, one cycle per access
- io_read_data  out  32  read data for the decoded address
- change  out  2  per-port change-pending flags (bit0 = port0)
- irq  out  1  interrupt request, high while any change bit set

## Operation
- Per port, identical independent pipeline: sync1 -> sync2 (2-flop synchroniser) -> candidate register + counter -> stable register.
- Each cycle: if sync2 != candidate then candidate <= sync2 and cnt <= 0; else if cnt < DEBOUNCE_CYCLES-1 then cnt <= cnt+1; else cnt holds (saturates).
- Acceptance: when sync2 == candidate, cnt == DEBOUNCE_CYCLES-1 and candidate != stable, then stable <= candidate and the port's change bit is set on the same edge.
- A candidate equal to the current stable value never sets change, even after a glitch.
- Any bit difference restarts the count; bouncing shorter than DEBOUNCE_CYCLES never reaches stable.
- Read decode on addr[7:2], combinational: 6'b110000 -> stable0; 6'b110001 -> stable1; 6'b110010 -> {30'b0, change}; all other codes -> 32'h0. io_read_data does not depend on rd_en.
- Read-to-clear: rd_en high with addr[7:2] == 6'b110010 clears both change bits at that edge. Reads of the data addresses never clear status.
- Simultaneous clear and new acceptance on the same port in the same cycle: set wins and the bit stays 1. The other port's bit clears normally.
- irq = change[0] | change[1], driven from registers with no combinational path from in_port*.
- Counter width = $clog2(DEBOUNCE_CYCLES); unsigned arithmetic, no wrap.

## Timing
- Reset (synchronous, takes priority over every other update): sync1, sync2, candidate, stable, cnt, change all 0. The outputs therefore reset to io_read_data = 0 for any address, change = 2'b00 and irq = 0.
- Latency: a raw value present before edge E and held appears in stable, and sets change, on edge E+2+DEBOUNCE_CYCLES. Example: DEBOUNCE_CYCLES=16 gives 18 edges.
- Read data is valid in the same cycle as addr, with zero wait states.
- Status clear takes effect at the rd_en edge; the status value read in that cycle is the pre-clear value.
- Reset asserted mid-count discards partial counts. After reset is released, an input already at a nonzero level is re-qualified from zero and takes the full latency.

## Structure
- Shared package io_input_pkg: address-code constants IO_IN0_SEL=6'b110000, IO_IN1_SEL=6'b110001, IO_STAT_SEL=6'b110010, and the data width constant IO_W=32.
- Sub-module io_input_debounce (parameter DEBOUNCE_CYCLES), instantiated once per port. It contains the synchroniser, candidate, counter and stable register, and outputs stable[31:0] and a one-cycle accept pulse.
- The top level holds the change register, the set/clear priority logic, the irq output and the read decode.

## Test plan
- Reset: assert reset 3 cycles with in_port0=32'hFFFF_FFFF -> stable0=0, change=0, irq=0 during reset and for 17 edges after release; stable0=32'hFFFF_FFFF and change[0]=1 on edge 18 after release (DEBOUNCE_CYCLES=16).
- Bounce: toggle in_port1 bit0 every 5 cycles for 100 cycles, then hold 1 -> stable1 stays 0 throughout bouncing; stable1=32'h1 exactly 18 edges after the final transition; change=2'b10.
- Glitch back to same value: stable0=32'h5, pulse in_port0=32'h7 for 10 cycles, return to 32'h5 -> stable0 remains 32'h5 and change[0] never sets.
- Read decode: stable0=32'hA5, stable1=32'h3C -> addr=32'h0000_00C0 reads 32'hA5; 32'h...C4 reads 32'h3C; 32'h...C8 reads status; 32'h...CC reads 0.
- Read-to-clear: change=2'b11, rd_en with addr 32'h...C8 -> that cycle reads 32'h3; next cycle change=0 and irq=0. Reading 32'h...C0 with rd_en leaves change unchanged.
- Set-vs-clear collision: arrange port0 acceptance on the same edge as a status-clear read -> change[0]=1 after the edge, change[1] cleared, irq remains 1.
